pll_lock_supervisor: RTL and testbench
======================================

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: PLL reset pulse length in clocks, min 1.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535: clocks to wait for lock before a retry, min 1.
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: consecutive clocks lock must hold before release, min 1.
REQ-004 SHALL have parameter MAX_RETRIES, default 7: timeout retries allowed before fault, range 0-255.
REQ-005 SHALL have port clock_in, input, 1: the single clock; all logic rising-edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port pll_locked, input, 1: PLL LOCK, asynchronous to clock_in.
REQ-008 SHALL have port pll_rst, output, 1: drives the PLL RST pin, active-high.
REQ-009 SHALL have port domain_reset, output, 1: reset for downstream logic, active-high.
REQ-010 SHALL have port ready, output, 1: high only in RUN.
REQ-011 SHALL have port fault, output, 1: high only in FAULT.
REQ-012 SHALL have port state, output, 3: encoding ASSERT_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.
REQ-013 SHALL have port relock_count, output, 8: count of lock losses seen in RUN.

Function
REQ-014 SHALL synchronise pll_locked through two flops; lock_sync is 2 cycles late, and only lock_sync is used.
REQ-015 SHALL drive every output as a decode of registered state or counters, with no combinational path from an input.
REQ-016 ASSERT_RST: pll_rst=1 for exactly RST_CYCLES cycles, then -> WAIT_LOCK with the cycle counter cleared.
REQ-017 WAIT_LOCK, lock_sync=1 -> STABLE, counter cleared; if the timeout expires in the same cycle, lock wins.
REQ-018 WAIT_LOCK, counter==LOCK_TIMEOUT-1 and lock_sync=0, retries<MAX_RETRIES -> retries+1, go to ASSERT_RST.
REQ-019 WAIT_LOCK, counter==LOCK_TIMEOUT-1 and lock_sync=0, retries==MAX_RETRIES -> FAULT.
REQ-020 STABLE, lock_sync=0 -> WAIT_LOCK with the timeout counter restarted and no PLL reset pulse.
REQ-021 STABLE, after STABLE_CYCLES consecutive cycles of lock_sync=1 -> RUN, and retries cleared to 0.
REQ-022 RUN: domain_reset=0, ready=1; lock_sync=0 -> ASSERT_RST, and domain_reset=1 on that same edge.
REQ-023 FAULT: pll_rst=1, domain_reset=1, fault=1; FAULT SHALL be left only via reset.
REQ-024 domain_reset SHALL equal (state!=RUN), ready SHALL equal (state==RUN), and pll_rst SHALL be 1 only in ASSERT_RST or FAULT.
REQ-025 SHALL size counters at $clog2(max(param)+1) bits, with no wrap inside any state.

Reset
REQ-026 On reset: state=ASSERT_RST, pll_rst=1, domain_reset=1, ready=0, fault=0, counters=0, retries=0, relock_count=0, sync flops=0.
REQ-027 Reset SHALL dominate every other event and SHALL restart ASSERT_RST from count 0, including when asserted mid-state.

Configuration
REQ-028 With PLL_SUPERVISOR_RELOCK_COUNT_EN defined: relock_count increments on each RUN->ASSERT_RST transition and saturates at 255.
REQ-029 Without PLL_SUPERVISOR_RELOCK_COUNT_EN: relock_count is tied to 0 and the counter logic is not generated.

Verification
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
REQ-030 Reset released, then pll_locked high from cycle 10 -> pll_rst high cycles 0-3; ready=1 and domain_reset=0 exactly 11 cycles after pll_locked is first sampled high.
REQ-031 pll_locked held 0 -> three pll_rst pulses of 4 cycles each, then fault=1, state=4, and pll_rst held 1 until reset.
REQ-032 pll_locked drops for 3 cycles during STABLE -> state returns to 1 with no pll_rst pulse; after lock resumes, ready rises 11 cycles after the re-rise.
REQ-033 In RUN, pll_locked drops -> domain_reset=1 and ready=0 3 cycles later, a 4-cycle pll_rst pulse follows, and relock_count=1 with the macro or 0 without it.
REQ-034 Reset asserted mid-STABLE -> all outputs at reset values the next cycle; 300 induced losses with the macro -> relock_count=255.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Sequences a PLL through reset, lock acquisition and lock qualification,
// then holds downstream logic in reset until the clock is known good.
// Lock loss in RUN restarts the PLL. Lock timeouts are retried a bounded
// number of times before the block parks in FAULT until reset.
// Optional feature macro: PLL_SUPERVISOR_RELOCK_COUNT_EN enables the
// saturating relock_count counter; without it relock_count is tied to 0.
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       domain_reset,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state,
  output logic [7:0] relock_count
);

  typedef enum logic [2:0] {
    ST_ASSERT_RST = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABLE     = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAULT      = 3'd4
  } state_t;

  // One shared cycle counter covers all three timed states, so it is sized
  // for the largest of the three limits.
  localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_P  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CW     = $clog2(MAX_P + 1);
  localparam int RW     = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);
  localparam logic [RW-1:0] RETRY_ONE   = RW'(1);

  logic [1:0]    sync_r;
  logic          lock_sync;
  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [RW-1:0] retries_r;

  // Two-flop synchroniser for the asynchronous PLL lock indication
  always_ff @(posedge clock_in) begin
    if (reset) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], pll_locked};
    end
  end

  assign lock_sync = sync_r[1];

  // Supervisor state machine with its cycle counter and retry counter
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_r   <= ST_ASSERT_RST;
      cnt_r     <= '0;
      retries_r <= '0;
    end else begin
      case (state_r)
        ST_ASSERT_RST: begin
          if (cnt_r == RST_LAST) begin
            state_r <= ST_WAIT_LOCK;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock is checked first so it wins over a coincident timeout.
          if (lock_sync) begin
            state_r <= ST_STABLE;
            cnt_r   <= '0;
          end else if (cnt_r == TO_LAST) begin
            cnt_r <= '0;
            if (retries_r < RETRY_MAX) begin
              retries_r <= retries_r + RETRY_ONE;
              state_r   <= ST_ASSERT_RST;
            end else begin
              state_r <= ST_FAULT;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_STABLE: begin
          // A glitch only restarts the lock wait; the PLL is not reset.
          if (!lock_sync) begin
            state_r <= ST_WAIT_LOCK;
            cnt_r   <= '0;
          end else if (cnt_r == STABLE_LAST) begin
            state_r   <= ST_RUN;
            cnt_r     <= '0;
            retries_r <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!lock_sync) begin
            state_r <= ST_ASSERT_RST;
            cnt_r   <= '0;
          end else begin
            cnt_r <= '0;
          end
        end
        ST_FAULT: begin
          state_r <= ST_FAULT;
          cnt_r   <= '0;
        end
        default: begin
          state_r <= ST_FAULT;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign state        = state_r;
  assign pll_rst      = (state_r == ST_ASSERT_RST) || (state_r == ST_FAULT);
  assign domain_reset = (state_r != ST_RUN);
  assign ready        = (state_r == ST_RUN);
  assign fault        = (state_r == ST_FAULT);

`ifdef PLL_SUPERVISOR_RELOCK_COUNT_EN
  logic [7:0] relock_r;

  // Count every RUN -> ASSERT_RST transition, saturating at 255
  always_ff @(posedge clock_in) begin
    if (reset) begin
      relock_r <= 8'd0;
    end else if ((state_r == ST_RUN) && !lock_sync && (relock_r != 8'hFF)) begin
      relock_r <= relock_r + 8'd1;
    end else begin
      relock_r <= relock_r;
    end
  end

  assign relock_count = relock_r;
`else
  assign relock_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed testbench for pll_lock_supervisor with RST_CYCLES=4,
// LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2. Inputs change 1 time
// unit after a rising edge, so the next rising edge is the first to sample
// them; outputs are sampled at that same point.
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       pll_rst;
  logic       domain_reset;
  logic       ready;
  logic       fault;
  logic [2:0] state;
  logic [7:0] relock_count;

  int checks = 0;
  int failures = 0;

`ifdef PLL_SUPERVISOR_RELOCK_COUNT_EN
  localparam bit RELOCK_EN = 1'b1;
`else
  localparam bit RELOCK_EN = 1'b0;
`endif

  pll_lock_supervisor #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .MAX_RETRIES  (2)
  ) dut (
    .clock_in    (clk),
    .reset       (rst),
    .pll_locked  (locked),
    .pll_rst     (pll_rst),
    .domain_reset(domain_reset),
    .ready       (ready),
    .fault       (fault),
    .state       (state),
    .relock_count(relock_count)
  );

  always #5 clk = ~clk;

  // {state, pll_rst, domain_reset, ready, fault, relock_count}
  logic [14:0] outs;
  assign outs = {state, pll_rst, domain_reset, ready, fault, relock_count};

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick(1);
      if (ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [14:0] exp_v;
    exp_v = {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    rst = 1'b1;
    locked = 1'b0;
    tick(2);
    checks++;
    if (outs !== exp_v) begin
      failures++;
      $display("FAIL reset_values got=%h want=%h", outs, exp_v);
    end
  endtask

  task automatic test_power_up();
    rst = 1'b1;
    locked = 1'b0;
    tick(2);
    rst = 1'b0;
    checks++;
    if (pll_rst !== 1'b1) begin
      failures++;
      $display("FAIL pu_pll_rst_cycle0 got=%b want=1", pll_rst);
    end
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      checks++;
      if (pll_rst !== 1'b1) begin
        failures++;
        $display("FAIL pu_pll_rst_cycle%0d got=%b want=1", k, pll_rst);
      end
    end
    tick(1);
    checks++;
    if (pll_rst !== 1'b0 || state !== 3'd1) begin
      failures++;
      $display("FAIL pu_wait_lock got pll_rst=%b state=%0d want 0/1", pll_rst, state);
    end
    tick(6);
    locked = 1'b1;
    tick(10);
    checks++;
    if (ready !== 1'b0 || domain_reset !== 1'b1) begin
      failures++;
      $display("FAIL pu_ready_early got ready=%b dr=%b want 0/1", ready, domain_reset);
    end
    tick(1);
    checks++;
    if (ready !== 1'b1 || domain_reset !== 1'b0 || state !== 3'd3) begin
      failures++;
      $display("FAIL pu_ready got ready=%b dr=%b state=%0d want 1/0/3", ready, domain_reset, state);
    end
  endtask

  task automatic test_timeout_fault();
    bit exp_rst;
    bit exp_fault;
    rst = 1'b1;
    locked = 1'b0;
    tick(2);
    rst = 1'b0;
    for (int k = 0; k < 80; k++) begin
      tick(1);
      exp_rst = (k < 3) || (k >= 23 && k < 27) || (k >= 47 && k < 51) || (k >= 71);
      exp_fault = (k >= 71);
      checks++;
      if (pll_rst !== exp_rst || fault !== exp_fault) begin
        failures++;
        $display("FAIL to_seq edge=%0d got pll_rst=%b fault=%b want %b/%b",
                 k, pll_rst, fault, exp_rst, exp_fault);
      end
    end
    checks++;
    if (state !== 3'd4 || domain_reset !== 1'b1 || ready !== 1'b0) begin
      failures++;
      $display("FAIL to_fault_state got state=%0d dr=%b ready=%b want 4/1/0", state, domain_reset, ready);
    end
    locked = 1'b1;
    tick(30);
    checks++;
    if (state !== 3'd4 || pll_rst !== 1'b1 || fault !== 1'b1) begin
      failures++;
      $display("FAIL fault_sticky got state=%0d pll_rst=%b fault=%b want 4/1/1", state, pll_rst, fault);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if (state !== 3'd0 || fault !== 1'b0) begin
      failures++;
      $display("FAIL fault_exit got state=%0d fault=%b want 0/0", state, fault);
    end
  endtask

  task automatic test_stable_drop();
    rst = 1'b1;
    locked = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(4);
    locked = 1'b1;
    tick(3);
    checks++;
    if (state !== 3'd2) begin
      failures++;
      $display("FAIL sd_enter_stable got state=%0d want 2", state);
    end
    tick(2);
    locked = 1'b0;
    tick(3);
    checks++;
    if (state !== 3'd1 || pll_rst !== 1'b0) begin
      failures++;
      $display("FAIL sd_back_to_wait got state=%0d pll_rst=%b want 1/0", state, pll_rst);
    end
    locked = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      checks++;
      if (pll_rst !== 1'b0 || ready !== 1'b0) begin
        failures++;
        $display("FAIL sd_relock edge=%0d got pll_rst=%b ready=%b want 0/0", k, pll_rst, ready);
      end
    end
    tick(1);
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL sd_ready got=%b want=1", ready);
    end
  endtask

  task automatic test_run_loss();
    bit ok;
    rst = 1'b1;
    locked = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(4);
    locked = 1'b1;
    tick(11);
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL rl_in_run got ready=%b want 1", ready);
    end
    locked = 1'b0;
    tick(2);
    checks++;
    if (domain_reset !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL rl_early got dr=%b ready=%b want 0/1", domain_reset, ready);
    end
    tick(1);
    checks++;
    if (domain_reset !== 1'b1 || ready !== 1'b0 || state !== 3'd0 || pll_rst !== 1'b1) begin
      failures++;
      $display("FAIL rl_loss got dr=%b ready=%b state=%0d pll_rst=%b want 1/0/0/1",
               domain_reset, ready, state, pll_rst);
    end
    tick(3);
    checks++;
    if (pll_rst !== 1'b1) begin
      failures++;
      $display("FAIL rl_pulse_len got pll_rst=%b want 1", pll_rst);
    end
    tick(1);
    checks++;
    if (pll_rst !== 1'b0 || state !== 3'd1) begin
      failures++;
      $display("FAIL rl_pulse_end got pll_rst=%b state=%0d want 0/1", pll_rst, state);
    end
    checks++;
    if (relock_count !== {7'd0, RELOCK_EN}) begin
      failures++;
      $display("FAIL rl_count got=%0d want=%0d", relock_count, RELOCK_EN);
    end
    locked = 1'b1;
    wait_ready(40, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rl_rerun_timeout got ready=%b want 1", ready);
    end
  endtask

  task automatic test_reset_mid_stable();
    logic [14:0] exp_v;
    exp_v = {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    locked = 1'b0;
    tick(3);
    locked = 1'b1;
    tick(4);
    tick(1);
    checks++;
    if (state !== 3'd2 || relock_count !== {6'd0, RELOCK_EN, 1'b0}) begin
      failures++;
      $display("FAIL rm_in_stable got state=%0d relock=%0d want 2/%0d", state, relock_count, 2 * RELOCK_EN);
    end
    tick(2);
    rst = 1'b1;
    tick(1);
    checks++;
    if (outs !== exp_v) begin
      failures++;
      $display("FAIL rm_reset_values got=%h want=%h", outs, exp_v);
    end
    rst = 1'b0;
    tick(3);
    checks++;
    if (state !== 3'd0 || pll_rst !== 1'b1) begin
      failures++;
      $display("FAIL rm_restart got state=%0d pll_rst=%b want 0/1", state, pll_rst);
    end
    tick(1);
    checks++;
    if (state !== 3'd1) begin
      failures++;
      $display("FAIL rm_restart_end got state=%0d want 1", state);
    end
  endtask

  task automatic test_relock_saturate();
    bit ok;
    bit timed_out;
    timed_out = 1'b0;
    rst = 1'b1;
    locked = 1'b1;
    tick(2);
    rst = 1'b0;
    wait_ready(40, ok);
    if (!ok) timed_out = 1'b1;
    for (int i = 0; i < 300 && !timed_out; i++) begin
      locked = 1'b0;
      tick(3);
      locked = 1'b1;
      wait_ready(40, ok);
      if (!ok) timed_out = 1'b1;
      if (i == 9) begin
        checks++;
        if (relock_count !== (RELOCK_EN ? 8'd10 : 8'd0)) begin
          failures++;
          $display("FAIL sat_count10 got=%0d want=%0d", relock_count, RELOCK_EN ? 10 : 0);
        end
      end
    end
    checks++;
    if (timed_out) begin
      failures++;
      $display("FAIL sat_ready_timeout got ready=%b want 1", ready);
    end
    checks++;
    if (relock_count !== (RELOCK_EN ? 8'd255 : 8'd0)) begin
      failures++;
      $display("FAIL sat_count got=%0d want=%0d", relock_count, RELOCK_EN ? 255 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_timeout_fault();
    test_stable_drop();
    test_run_loss();
    test_reset_mid_stable();
    test_relock_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
